// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU parameters for the fetch stage: reset PC, exception vector,
// text-segment bounds, exception codes, the nop word and the sequencer states.
package fetch_sequencer_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] TEXT_BASE  = 32'h0000_3000;
    localparam logic [31:0] TEXT_LAST  = 32'h0000_4FFC;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [4:0]  EXC_NONE   = 5'd31;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        SQUASH   = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check for an instruction fetch address:
// the address must be word aligned and fall inside the text segment.
module fetch_addr_check
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0] addr,
    output logic        addr_ok
);

    // Aligned and within [TEXT_BASE, TEXT_LAST]
    always_comb begin
        addr_ok = (addr[1:0] == 2'b00) && (addr >= TEXT_BASE) && (addr <= TEXT_LAST);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the instruction-memory request,
// maintains the fetch PC, a one-entry skid buffer and the IF/ID register.
// Optional feature: define FETCH_ADDR_CHECK_EN to raise AdEL on illegal
// fetch addresses instead of issuing the request.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic        err_signal,
    input  logic        eret_en,
    input  logic [31:0] epc_data,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic        err_out,
    output logic [4:0]  exc_code
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  squash_addr;
    logic         started;

    // The skid entry is occupied exactly while state == BUFFERED.
    logic [31:0]  buf_pc;
    logic [31:0]  buf_pc4;
    logic [31:0]  buf_instr;
    logic         buf_err;
    logic         if_err;

    logic         addr_ok;
    logic         addr_fault;
    logic [31:0]  fetch_addr;
    logic [31:0]  flush_target;
    logic [31:0]  redir_target;
    logic [31:0]  word_data;
    logic         flush;
    logic         redirect;
    logic         req_active;
    logic         got_word;

    fetch_addr_check u_addr_check (
        .addr    (pc),
        .addr_ok (addr_ok)
    );

`ifdef FETCH_ADDR_CHECK_EN
    assign addr_fault = ~addr_ok;
`else
    // Check result is deliberately not consumed when the check is compiled out.
    logic unused_addr_ok;
    assign unused_addr_ok = addr_ok;
    assign addr_fault     = 1'b0;
`endif

    // Next-PC selection, request generation and exception reporting
    always_comb begin
        fetch_addr   = word_align(pc);
        flush        = err_signal | eret_en;
        flush_target = err_signal ? EXC_VECTOR : epc_data;
        redirect     = ~stall & (branch | jump);
        redir_target = branch ? branch_addr : jump_addr;
        req_active   = started && ((state == SQUASH) || ((state == FETCH) && !addr_fault));
        got_word     = started && (state == FETCH) && (addr_fault || im_ack);
        word_data    = addr_fault ? NOP_INSTR : im_rdata;
        im_req       = req_active;
        im_addr      = (state == SQUASH) ? squash_addr : fetch_addr;
        // A frozen IF/ID reports no exception; it surfaces once the stage advances.
        err_out      = if_err & ~stall;
        exc_code     = err_out ? EXC_ADEL : EXC_NONE;
    end

    // Sequencer state, fetch PC, skid buffer and IF/ID register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            squash_addr <= RESET_PC;
            started     <= 1'b0;
            buf_pc      <= RESET_PC;
            buf_pc4     <= RESET_PC + 32'd4;
            buf_instr   <= NOP_INSTR;
            buf_err     <= 1'b0;
            pc_out      <= RESET_PC;
            pc4_out     <= RESET_PC + 32'd4;
            instr_out   <= NOP_INSTR;
            valid_out   <= 1'b0;
            if_err      <= 1'b0;
        end else begin
            started <= 1'b1;
            if (flush) begin
                pc_out    <= flush_target;
                pc4_out   <= flush_target + 32'd4;
                instr_out <= NOP_INSTR;
                valid_out <= 1'b0;
                if_err    <= 1'b0;
                buf_err   <= 1'b0;
                pc        <= flush_target + 32'd4;
                if (req_active && !im_ack) begin
                    state       <= SQUASH;
                    squash_addr <= im_addr;
                end else begin
                    state <= FETCH;
                end
            end else begin
                unique case (state)
                    FETCH: begin
                        if (redirect) begin
                            pc        <= redir_target;
                            valid_out <= 1'b0;
                            if_err    <= 1'b0;
                            if (req_active && !im_ack) begin
                                state       <= SQUASH;
                                squash_addr <= im_addr;
                            end
                        end else if (got_word) begin
                            pc <= pc + 32'd4;
                            if (stall) begin
                                buf_pc    <= fetch_addr;
                                buf_pc4   <= pc + 32'd4;
                                buf_instr <= word_data;
                                buf_err   <= addr_fault;
                                state     <= BUFFERED;
                            end else begin
                                pc_out    <= fetch_addr;
                                pc4_out   <= pc + 32'd4;
                                instr_out <= word_data;
                                valid_out <= 1'b1;
                                if_err    <= addr_fault;
                            end
                        end else if (!stall) begin
                            valid_out <= 1'b0;
                            if_err    <= 1'b0;
                        end
                    end
                    BUFFERED: begin
                        if (!stall) begin
                            pc_out    <= buf_pc;
                            pc4_out   <= buf_pc4;
                            instr_out <= buf_instr;
                            valid_out <= 1'b1;
                            if_err    <= buf_err;
                            state     <= FETCH;
                            if (redirect) begin
                                pc <= redir_target;
                            end
                        end
                    end
                    SQUASH: begin
                        if (redirect) begin
                            pc <= redir_target;
                        end
                        if (im_ack) begin
                            state <= FETCH;
                        end
                        if (!stall) begin
                            valid_out <= 1'b0;
                            if_err    <= 1'b0;
                        end
                    end
                    default: begin
                        state <= FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a directed vector table covering
// reset, streaming, skid buffering, squash, flush and address-check cases,
// a mid-request reset sequence, then randomized stall/ack traffic checked
// against an in-order instruction stream model.
module tb_fetch_sequencer;

    localparam logic [31:0] MAGIC = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        jump;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic        err_signal;
    logic        eret_en;
    logic [31:0] epc_data;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic        err_out;
    logic [4:0]  exc_code;

    int errors = 0;
    int checks = 0;

    // Field order: stall, ack, branch, jump, err, eret, target,
    //              exp_req, chk_addr, exp_addr, exp_pc, exp_instr,
    //              exp_valid, chk_valid, exp_err
    typedef struct {
        logic        stall;
        logic        ack;
        logic        branch;
        logic        jump;
        logic        err;
        logic        eret;
        logic [31:0] target;
        logic        exp_req;
        logic        chk_addr;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        chk_valid;
        logic        exp_err;
    } vec_t;

    vec_t vecs [19];

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .branch_addr (branch_addr),
        .jump_addr   (jump_addr),
        .err_signal  (err_signal),
        .eret_en     (eret_en),
        .epc_data    (epc_data),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .pc_out      (pc_out),
        .pc4_out     (pc4_out),
        .instr_out   (instr_out),
        .valid_out   (valid_out),
        .err_out     (err_out),
        .exc_code    (exc_code)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearInputs();
        stall       = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        branch_addr = 32'h0;
        jump_addr   = 32'h0;
        err_signal  = 1'b0;
        eret_en     = 1'b0;
        epc_data    = 32'h0;
        im_ack      = 1'b0;
        im_rdata    = 32'h0;
    endtask

    // Called at a negedge: drive one cycle, check the request, then the IF/ID result
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        stall       = v.stall;
        im_ack      = v.ack;
        branch      = v.branch;
        jump        = v.jump;
        branch_addr = v.target;
        jump_addr   = v.target;
        err_signal  = v.err;
        eret_en     = v.eret;
        epc_data    = v.target;
        im_rdata    = im_addr;
        #1;
        tag = $sformatf("v%0d_im_req", idx);
        checkOutput(tag, {31'b0, im_req}, {31'b0, v.exp_req});
        if (v.chk_addr) begin
            tag = $sformatf("v%0d_im_addr", idx);
            checkOutput(tag, im_addr, v.exp_addr);
        end
        @(negedge clk);
        tag = $sformatf("v%0d_pc_out", idx);
        checkOutput(tag, pc_out, v.exp_pc);
        tag = $sformatf("v%0d_pc4_out", idx);
        checkOutput(tag, pc4_out, v.exp_pc + 32'd4);
        tag = $sformatf("v%0d_instr_out", idx);
        checkOutput(tag, instr_out, v.exp_instr);
        if (v.chk_valid) begin
            tag = $sformatf("v%0d_valid_out", idx);
            checkOutput(tag, {31'b0, valid_out}, {31'b0, v.exp_valid});
        end
        tag = $sformatf("v%0d_err_out", idx);
        checkOutput(tag, {31'b0, err_out}, {31'b0, v.exp_err});
        tag = $sformatf("v%0d_exc_code", idx);
        checkOutput(tag, {27'b0, exc_code}, v.exp_err ? 32'd4 : 32'd31);
    endtask

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_im_req"},    {31'b0, im_req},    32'd0);
        checkOutput({pfx, "_pc_out"},    pc_out,             32'h0000_3000);
        checkOutput({pfx, "_pc4_out"},   pc4_out,            32'h0000_3004);
        checkOutput({pfx, "_instr_out"}, instr_out,          32'h0);
        checkOutput({pfx, "_valid_out"}, {31'b0, valid_out}, 32'd0);
        checkOutput({pfx, "_err_out"},   {31'b0, err_out},   32'd0);
        checkOutput({pfx, "_exc_code"},  {27'b0, exc_code},  32'd31);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] last_pc;
        logic        prev_stall;
        logic        prev_req;
        logic        prev_ack;
        int          delivered;
        int          cyc;

        vecs[0]  = '{0,1,0,0,0,0,32'h0,    0,1,32'h3000, 32'h3000,32'h0,    0,1,0};
        vecs[1]  = '{0,1,0,0,0,0,32'h0,    1,1,32'h3000, 32'h3000,32'h3000, 1,1,0};
        vecs[2]  = '{0,1,0,0,0,0,32'h0,    1,1,32'h3004, 32'h3004,32'h3004, 1,1,0};
        vecs[3]  = '{1,1,0,0,0,0,32'h0,    1,1,32'h3008, 32'h3004,32'h3004, 1,1,0};
        vecs[4]  = '{0,1,0,0,0,0,32'h0,    0,0,32'h0,    32'h3008,32'h3008, 1,1,0};
        vecs[5]  = '{0,1,0,0,0,0,32'h0,    1,1,32'h300C, 32'h300C,32'h300C, 1,1,0};
        vecs[6]  = '{0,0,1,0,0,0,32'h3100, 1,1,32'h3010, 32'h300C,32'h300C, 0,1,0};
        vecs[7]  = '{0,0,0,0,0,0,32'h0,    1,1,32'h3010, 32'h300C,32'h300C, 0,1,0};
        vecs[8]  = '{0,0,0,0,0,0,32'h0,    1,1,32'h3010, 32'h300C,32'h300C, 0,1,0};
        vecs[9]  = '{0,1,0,0,0,0,32'h0,    1,1,32'h3010, 32'h300C,32'h300C, 0,1,0};
        vecs[10] = '{0,1,0,0,0,0,32'h0,    1,1,32'h3100, 32'h3100,32'h3100, 1,1,0};
        vecs[11] = '{1,1,0,0,0,0,32'h0,    1,1,32'h3104, 32'h3100,32'h3100, 1,1,0};
        vecs[12] = '{1,0,0,0,1,0,32'h0,    0,0,32'h0,    32'h4180,32'h0,    0,1,0};
        vecs[13] = '{0,1,0,0,0,0,32'h0,    1,1,32'h4184, 32'h4184,32'h4184, 1,1,0};
        vecs[14] = '{0,1,0,1,0,0,32'h5000, 1,1,32'h4188, 32'h4184,32'h4184, 0,1,0};
`ifdef FETCH_ADDR_CHECK_EN
        vecs[15] = '{0,1,0,0,0,0,32'h0,    0,0,32'h0,    32'h5000,32'h0,    1,0,1};
        vecs[16] = '{1,0,0,0,0,0,32'h0,    0,0,32'h0,    32'h5000,32'h0,    1,0,0};
        vecs[17] = '{0,1,0,0,0,1,32'h3200, 0,0,32'h0,    32'h3200,32'h0,    0,1,0};
`else
        vecs[15] = '{0,1,0,0,0,0,32'h0,    1,1,32'h5000, 32'h5000,32'h5000, 1,1,0};
        vecs[16] = '{1,0,0,0,0,0,32'h0,    1,1,32'h5004, 32'h5000,32'h5000, 1,1,0};
        vecs[17] = '{0,1,0,0,0,1,32'h3200, 1,1,32'h5004, 32'h3200,32'h0,    0,1,0};
`endif
        vecs[18] = '{0,1,0,0,0,0,32'h0,    1,1,32'h3204, 32'h3204,32'h3204, 1,1,0};

        clearInputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] reset in the middle of an outstanding request");
        clearInputs();
        #1;
        checkOutput("midreset_pending_req", {31'b0, im_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkResetState("midreset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(vecs[i], 100 + i);
        end

        $display("[TB] randomized stall/ack traffic");
        clearInputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_pc    = 32'h0000_3000;
        last_pc   = 32'h0000_3000;
        delivered = 0;
        cyc       = 0;
        stall     = ($urandom_range(0, 3) == 0);
        im_ack    = $urandom_range(0, 1) == 1;
        im_rdata  = im_addr ^ MAGIC;
        prev_stall = stall;
        prev_req   = im_req;
        prev_ack   = im_ack;
        while (delivered < 40 && cyc < 1500) begin
            @(negedge clk);
            cyc++;
            if (!prev_stall && valid_out) begin
                checkOutput("rand_pc_out",    pc_out,    exp_pc);
                checkOutput("rand_pc4_out",   pc4_out,   exp_pc + 32'd4);
                checkOutput("rand_instr_out", instr_out, exp_pc ^ MAGIC);
                last_pc = exp_pc;
                exp_pc  = exp_pc + 32'd4;
                delivered++;
            end else if (prev_stall) begin
                checkOutput("rand_held_pc", pc_out, last_pc);
            end
            if (prev_req && !prev_ack) begin
                checkOutput("rand_req_held", {31'b0, im_req}, 32'd1);
            end
            if (im_req) begin
                checkOutput("rand_im_addr", im_addr, exp_pc);
            end
            stall      = ($urandom_range(0, 3) == 0);
            im_ack     = $urandom_range(0, 1) == 1;
            im_rdata   = im_addr ^ MAGIC;
            prev_stall = stall;
            prev_req   = im_req;
            prev_ack   = im_ack;
        end
        checks++;
        if (delivered < 40) begin
            errors++;
            $display("[TB] FAIL rand_progress: delivered %0d instructions, want 40 within 1500 cycles", delivered);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold IF/ID outputs
- branch, jump  in  1  redirect requests from ID
- branch_addr, jump_addr  in  32  redirect targets
- err_signal  in  1  exception flush, vector 0x0000_4180
- eret_en  in  1  return flush to epc_data
- epc_data  in  32  eret target
- im_req  out  1  instruction-memory request
- im_addr  out  32  word-aligned fetch address
- im_ack  in  1  read data valid, may arrive same cycle as im_req
- im_rdata  in  32  instruction word
- pc_out, pc4_out, instr_out  out  32  IF/ID register
- valid_out  out  1  instr_out is a real fetch
- err_out  out  1  fetch exception flag
- exc_code  out  5  4 = AdEL, 31 = none

Function
REQ-002 SHALL keep an internal 32-bit fetch PC; next-PC priority: err_signal > eret_en > branch > jump > PC+4.
REQ-003 SHALL honour err_signal/eret_en even under stall; SHALL ignore branch/jump while stall=1.
REQ-004 SHALL have states FETCH, BUFFERED, SQUASH.
REQ-005 FETCH: im_req=1, im_addr=PC; on im_ack with stall=0, load IF/ID (pc_out=PC, pc4_out=PC+4, instr_out=im_rdata, valid_out=1) and advance PC in the same edge: one instruction/cycle with zero-wait memory.
REQ-006 FETCH, im_ack with stall=1: SHALL capture word, PC and PC+4 in a one-entry skid buffer and go to BUFFERED; IF/ID held.
REQ-007 BUFFERED: im_req=0; when stall=0, skid entry SHALL move to IF/ID next edge, then FETCH.
REQ-008 Redirect in FETCH without im_ack: im_addr SHALL stay unchanged until ack (address stable while im_req=1); target latched in PC; go to SQUASH.
REQ-009 SQUASH: im_req=1 at old address; returned word SHALL be discarded; then FETCH at the latched target.
REQ-010 A redirect in the same cycle as im_ack SHALL drop the acked word and go directly to FETCH at the target.
REQ-011 err_signal/eret_en SHALL empty the skid buffer and load IF/ID with pc_out=target, pc4_out=target+4, instr_out=0, valid_out=0, err_out=0, exc_code=31 on the next edge.
REQ-012 Fetch address check failure: misaligned, above 0x0000_4FFC or below 0x0000_3000. SHALL NOT assert im_req. SHALL present instr_out=0, err_out=1, exc_code=4, pc_out={PC[31:2],2'b00} as if acked in one cycle.
REQ-013 While stall=1 with IF/ID held, err_out SHALL be 0 and exc_code SHALL be 31.
REQ-014 PC arithmetic SHALL be 32-bit modulo; PC+4 wraps without flag.

Reset
REQ-015 On reset: state FETCH, PC=0x0000_3000, pc_out=0x0000_3000, pc4_out=0x0000_3004, instr_out=0, valid_out=0, err_out=0, exc_code=31, skid buffer empty, im_req=0.
REQ-016 reset asserted mid-request SHALL abandon it; any im_ack in the first cycle after release SHALL be ignored.

Configuration
REQ-017 With FETCH_ADDR_CHECK_EN defined, REQ-012 applies. Without it, every PC is fetched with im_addr={PC[31:2],2'b00}; err_out is constant 0 and exc_code constant 31.

Structure
REQ-018 Reset PC, exception vector, text bounds 0x3000/0x4FFC, AdEL=4, no-exception=31 and nop=0 SHALL live in the shared CPU parameter package, along with the state encoding.
REQ-019 Address check SHALL be a combinational sub-module fetch_addr_check.

Verification
REQ-020 Reset release, im_ack tied 1, im_rdata=PC: pc_out = 0x3000, 0x3004, 0x3008 on consecutive cycles with valid_out=1.
REQ-021 stall=1 at the ack of 0x3008: IF/ID holds 0x3004; BUFFERED with im_req=0. stall=0: 0x3008, then 0x300C.
REQ-022 im_ack delayed 3 cycles; branch to 0x3100 in cycle 1: im_addr stays 0x3010 until ack, data dropped, next im_addr=0x3100.
REQ-023 err_signal with stall=1 and buffer full: next edge pc_out=0x4180, instr_out=0; following fetch at 0x4184.
REQ-024 jump to 0x5000 with FETCH_ADDR_CHECK_EN: no im_req; err_out=1, exc_code=4, instr_out=0. Without the macro: im_req=1, im_addr=0x5000.
